// File: rtl/raw10_unpacker.sv
// raw10_unpacker: turns the 16-bit RAW10 payload stream into 4-pixel beats.
// Every packed 5-byte group (B0..B3 = pixel MSBs, B4 = the 2-bit LSBs) is
// emitted as one 40-bit beat. The block also flags frame start and line end.
// Optional: define RAW10_UNPACK_LINE_STAT_EN to compile in the line active
// flag, the per-line pixel counter, line_pix_cnt and line_err.

// One pixel lane: 8 MSBs from the byte, 2 LSBs from the shared LSB byte.
module raw10_lane (
    input  logic [7:0] msb,
    input  logic [1:0] lsb,
    output logic [9:0] pix
);
    assign pix = {msb, lsb};
endmodule

module raw10_unpacker #(
    parameter int CNT_W = 16
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             raw_vld,
    input  logic [15:0]      raw_data,
    input  logic             raw_vsync,
    input  logic             packet_done,
    output logic             pix_vld,
    output logic [39:0]      pix_data,
    output logic             pix_sof,
    output logic             line_done,
    output logic [CNT_W-1:0] line_pix_cnt,
    output logic             line_err
);
    localparam int NUM_LANES = 4;
    localparam int PIX_W     = 10;

    // Rn: n bytes currently held in the byte buffer
    typedef enum logic [2:0] {R0, R1, R2, R3, R4} res_t;

    res_t                              res_q, res_d;
    logic [3:0][7:0]                   byte_q, byte_d;
    logic [4:0][7:0]                   grp;
    logic                              emit;
    logic                              sof_pend;
    logic                              vld_in;
    logic [NUM_LANES-1:0][PIX_W-1:0]   lane_pix;

    // vsync wins over data arriving in the same cycle
    assign vld_in = raw_vld & ~raw_vsync;

    // Residue step: absorb the incoming word and assemble a group when complete
    always_comb begin
        res_d  = res_q;
        byte_d = byte_q;
        emit   = 1'b0;
        grp    = '0;
        if (vld_in) begin
            case (res_q)
                R0: begin byte_d[0] = raw_data[7:0]; byte_d[1] = raw_data[15:8]; res_d = R2; end
                R1: begin byte_d[1] = raw_data[7:0]; byte_d[2] = raw_data[15:8]; res_d = R3; end
                R2: begin byte_d[2] = raw_data[7:0]; byte_d[3] = raw_data[15:8]; res_d = R4; end
                R3: begin
                    emit  = 1'b1;
                    grp   = {raw_data[15:8], raw_data[7:0], byte_q[2:0]};
                    res_d = R0;
                end
                R4: begin
                    emit      = 1'b1;
                    grp       = {raw_data[7:0], byte_q};
                    byte_d[0] = raw_data[15:8];
                    res_d     = R1;
                end
                default: res_d = R0;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        raw10_lane u_lane (
            .msb (grp[k]),
            .lsb (grp[4][2*k+1:2*k]),
            .pix (lane_pix[k])
        );
    end

`ifdef RAW10_UNPACK_LINE_STAT_EN
    logic             act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_sum;

    // Post-data line flag and saturating pixel count for this cycle
    always_comb begin
        act_d   = act_q | raw_vld;
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(4);
        cnt_d   = cnt_q;
        if (emit) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
`endif

    // Registered beat output, residue state, frame-start and line-end tracking
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            res_q        <= R0;
            byte_q       <= '0;
            sof_pend     <= 1'b0;
            pix_vld      <= 1'b0;
            pix_data     <= '0;
            pix_sof      <= 1'b0;
            line_done    <= 1'b0;
            line_pix_cnt <= '0;
            line_err     <= 1'b0;
`ifdef RAW10_UNPACK_LINE_STAT_EN
            act_q        <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            pix_vld      <= emit;
            pix_data     <= emit ? lane_pix : '0;
            pix_sof      <= emit & sof_pend;
            line_done    <= 1'b0;
            line_pix_cnt <= '0;
            line_err     <= 1'b0;
            if (raw_vsync) begin
                // abort any partial line silently and re-align to byte 0
                sof_pend <= 1'b1;
                res_q    <= R0;
`ifdef RAW10_UNPACK_LINE_STAT_EN
                act_q    <= 1'b0;
                cnt_q    <= '0;
`endif
            end else begin
                if (emit) sof_pend <= 1'b0;
                res_q  <= res_d;
                byte_q <= byte_d;
`ifdef RAW10_UNPACK_LINE_STAT_EN
                if (packet_done && act_d) begin
                    line_done    <= 1'b1;
                    line_pix_cnt <= cnt_d;
                    line_err     <= (res_d != R0);
                    res_q        <= R0;
                    act_q        <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    act_q <= act_d;
                    cnt_q <= cnt_d;
                end
`else
                if (packet_done) begin
                    line_done <= 1'b1;
                    res_q     <= R0;
                end
`endif
            end
        end
    end
endmodule
